change_return_sequencer: RTL and testbench
==========================================

Name: change_return_sequencer

Overview:
- Executes a coin-return request against the coin hopper.
- On a start pulse it latches the customer balance, then issues coins greedily, one at a time, over a valid/ack handshake.
- Each acknowledged coin decrements the balance; the block stops when the balance is zero or change cannot be made.
- Sits between the vending controller's return decision and the physical hopper driver.

Parameters:
- NUM_COINS, 3, number of coin denominations (index 0 = smallest).
- TOTAL_BITS, 31, width of the balance.
- COIN0_VALUE, 100, value of coin 0.
- COIN1_VALUE, 500, value of coin 1.
- COIN2_VALUE, 1000, value of coin 2.
- ACK_TIMEOUT, 15, maximum cycles o_coin_valid may wait for i_coin_ack.

Ports:
- clk  input  1  clock.
- reset_n  input  1  synchronous, active-low reset.
- i_start_return  input  1  single-cycle request to return the balance.
- i_total  input  TOTAL_BITS  balance to return; sampled only with an accepted start.
- i_stock_empty  input  NUM_COINS  bit k = hopper k empty, so coin k is not eligible.
- i_coin_ack  input  1  hopper has dispensed the offered coin.
- o_coin_valid  output  1  coin offer pending.
- o_coin_sel  output  NUM_COINS  one-hot selected coin; zero when not valid.
- o_busy  output  1  sequence in progress (any state other than IDLE).
- o_done  output  1  one-cycle pulse: balance fully returned.
- o_error  output  1  one-cycle pulse: change impossible or ack timeout.
- o_remaining  output  TOTAL_BITS  balance still owed.
- o_coin_count  output  8  coins dispensed in the current or last sequence; saturates at 255.

Behaviour:
- All outputs are registered. Reset (reset_n=0 at a clk edge) takes priority over everything else, including mid-handshake.
- Reset values: state=IDLE, o_coin_valid=0, o_coin_sel=0, o_busy=0, o_done=0, o_error=0, o_remaining=0, o_coin_count=0, timeout counter=0.
- States: IDLE, SELECT, OFFER.
- IDLE:
  - On i_start_return=1: load o_remaining<=i_total, clear o_coin_count, go to SELECT.
  - Otherwise hold; o_remaining and o_coin_count keep their last values.
- SELECT:
  - If o_remaining==0: pulse o_done, go to IDLE.
  - Otherwise choose the highest k with COINk_VALUE<=o_remaining and i_stock_empty[k]=0. Then set o_coin_sel=one-hot k, o_coin_valid<=1, clear the timeout counter, go to OFFER.
  - If no such k exists: pulse o_error, go to IDLE, leave o_remaining unchanged.
- OFFER:
  - o_coin_valid and o_coin_sel stay stable until the ack.
  - On i_coin_ack=1: o_remaining <= o_remaining − value(k), o_coin_count +1 (saturating at 255), deassert valid and clear sel, go to SELECT.
  - Without an ack, the counter increments each cycle. When the counter reaches ACK_TIMEOUT with no ack: pulse o_error, drop valid, go to IDLE.
  - Ack and timeout in the same cycle: the ack wins.
- Latency:
  - Start sampled at edge n → o_coin_valid high after edge n+2.
  - Ack at edge m → next offer valid after edge m+2.
  - Zero balance: o_done is high after edge n+2.
- Ignored inputs:
  - i_start_return while o_busy=1.
  - i_coin_ack outside OFFER.
  - i_stock_empty changes during OFFER; eligibility is evaluated only in SELECT.
- Arithmetic: subtraction is unsigned at TOTAL_BITS; greedy selection guarantees no underflow.
- o_done and o_error are never high together, and each lasts exactly one cycle.

Test Plan:
- Start with i_total=1600, no stock empty, ack 1 cycle after each valid → o_coin_sel = 100, 010, 001 in order; o_remaining 600, 100, 0; o_done pulse; o_coin_count=3.
- i_total=1000 with i_stock_empty=100 → two 010 offers; o_remaining 500 then 0; o_done; o_coin_count=2.
- i_total=50 → no offer; o_error pulse 2 cycles after start; o_remaining=50; o_busy back to 0.
- i_total=500, ack never asserted → valid held exactly ACK_TIMEOUT=15 cycles, then o_error; o_remaining=500.
- i_total=0 → o_done 2 cycles after start, o_coin_valid never asserted.
- Reset mid-OFFER (i_total=1000) → next cycle all outputs at reset values. Second start while busy (i_total=9999) → ignored; o_remaining unaffected.

Source files
------------

// File: rtl/change_return_sequencer.sv
// change_return_sequencer
// Returns a latched customer balance as coins, largest eligible denomination
// first. Each coin is offered to the hopper over a valid/ack handshake. The
// sequence ends with o_done when the balance is zero, or with o_error when no
// coin fits or the hopper fails to acknowledge in time.
module change_return_sequencer #(
    parameter int NUM_COINS   = 3,
    parameter int TOTAL_BITS  = 31,
    parameter int COIN0_VALUE = 100,
    parameter int COIN1_VALUE = 500,
    parameter int COIN2_VALUE = 1000,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start_return,
    input  logic [TOTAL_BITS-1:0] i_total,
    input  logic [NUM_COINS-1:0]  i_stock_empty,
    input  logic                  i_coin_ack,
    output logic                  o_coin_valid,
    output logic [NUM_COINS-1:0]  o_coin_sel,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [TOTAL_BITS-1:0] o_remaining,
    output logic [7:0]            o_coin_count
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        OFFER  = 2'd2
    } state_t;

    // Denomination table. Indices beyond the three defined coins have value
    // zero and are never eligible.
    function automatic logic [TOTAL_BITS-1:0] coin_value(input int k);
        case (k)
            0:       return TOTAL_BITS'(COIN0_VALUE);
            1:       return TOTAL_BITS'(COIN1_VALUE);
            2:       return TOTAL_BITS'(COIN2_VALUE);
            default: return '0;
        endcase
    endfunction

    state_t                state_reg, state_next;
    logic                  coin_valid_reg, coin_valid_next;
    logic [NUM_COINS-1:0]  coin_sel_reg, coin_sel_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  error_reg, error_next;
    logic [TOTAL_BITS-1:0] remaining_reg, remaining_next;
    logic [7:0]            coin_count_reg, coin_count_next;
    logic [TMR_W-1:0]      timer_reg, timer_next;

    logic [NUM_COINS-1:0]  eligible;
    logic [NUM_COINS-1:0]  pick_sel;
    logic                  pick_found;
    logic [TOTAL_BITS-1:0] offer_value;

    // A coin is eligible when it is stocked and does not exceed the balance.
    generate
        for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_eligible
            assign eligible[gi] = !i_stock_empty[gi]
                                && (coin_value(gi) != '0)
                                && (coin_value(gi) <= remaining_reg);
        end
    endgenerate

    // Greedy pick: the highest eligible index wins.
    always_comb begin
        pick_sel   = '0;
        pick_found = 1'b0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (eligible[k]) begin
                pick_sel    = '0;
                pick_sel[k] = 1'b1;
                pick_found  = 1'b1;
            end
        end
    end

    // Value of the coin currently on offer, decoded from the one-hot select.
    always_comb begin
        offer_value = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (coin_sel_reg[k]) begin
                offer_value = offer_value | coin_value(k);
            end
        end
    end

    // Next-state and registered-output logic of the return sequence.
    always_comb begin
        state_next      = state_reg;
        coin_valid_next = coin_valid_reg;
        coin_sel_next   = coin_sel_reg;
        done_next       = 1'b0;
        error_next      = 1'b0;
        remaining_next  = remaining_reg;
        coin_count_next = coin_count_reg;
        timer_next      = timer_reg;

        case (state_reg)
            IDLE: begin
                if (i_start_return) begin
                    remaining_next  = i_total;
                    coin_count_next = '0;
                    state_next      = SELECT;
                end
            end
            SELECT: begin
                if (remaining_reg == '0) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (pick_found) begin
                    coin_sel_next   = pick_sel;
                    coin_valid_next = 1'b1;
                    timer_next      = '0;
                    state_next      = OFFER;
                end else begin
                    error_next = 1'b1;
                    state_next = IDLE;
                end
            end
            OFFER: begin
                // An ack arriving on the timeout cycle still counts.
                if (i_coin_ack) begin
                    remaining_next  = remaining_reg - offer_value;
                    if (coin_count_reg != 8'hFF) begin
                        coin_count_next = coin_count_reg + 8'd1;
                    end
                    coin_valid_next = 1'b0;
                    coin_sel_next   = '0;
                    state_next      = SELECT;
                end else if ((timer_reg + 1'b1) == TMR_W'(ACK_TIMEOUT)) begin
                    error_next      = 1'b1;
                    coin_valid_next = 1'b0;
                    coin_sel_next   = '0;
                    timer_next      = '0;
                    state_next      = IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                coin_valid_next = 1'b0;
                coin_sel_next   = '0;
                state_next      = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            coin_valid_reg <= 1'b0;
            coin_sel_reg   <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            remaining_reg  <= '0;
            coin_count_reg <= '0;
            timer_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            coin_valid_reg <= coin_valid_next;
            coin_sel_reg   <= coin_sel_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            error_reg      <= error_next;
            remaining_reg  <= remaining_next;
            coin_count_reg <= coin_count_next;
            timer_reg      <= timer_next;
        end
    end

    assign o_coin_valid = coin_valid_reg;
    assign o_coin_sel   = coin_sel_reg;
    assign o_busy       = busy_reg;
    assign o_done       = done_reg;
    assign o_error      = error_reg;
    assign o_remaining  = remaining_reg;
    assign o_coin_count = coin_count_reg;

endmodule

// File: tb/tb_change_return_sequencer.sv
// Bench for change_return_sequencer: a greedy reference model queues the
// expected coin selections and balances for each return request, and they are
// popped and compared as the DUT offers coins.
module tb_change_return_sequencer;

    logic        clk;
    logic        reset_n;
    logic        i_start_return;
    logic [30:0] i_total;
    logic [2:0]  i_stock_empty;
    logic        i_coin_ack;
    logic        o_coin_valid;
    logic [2:0]  o_coin_sel;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [30:0] o_remaining;
    logic [7:0]  o_coin_count;

    int n_checks = 0;
    int n_pass   = 0;

    int         cv [3] = '{100, 500, 1000};
    logic [2:0] exp_sel_q [$];
    int         exp_rem_q [$];

    change_return_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_start_return (i_start_return),
        .i_total        (i_total),
        .i_stock_empty  (i_stock_empty),
        .i_coin_ack     (i_coin_ack),
        .o_coin_valid   (o_coin_valid),
        .o_coin_sel     (o_coin_sel),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_error        (o_error),
        .o_remaining    (o_remaining),
        .o_coin_count   (o_coin_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance negedges until an offer, done or error appears (bounded).
    task automatic wait_event(input string tag, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(o_coin_valid || o_done || o_error) && lat < 40);
        if (!(o_coin_valid || o_done || o_error)) begin
            check({tag, " event_seen"}, 32'(o_coin_valid | o_done | o_error), 1);
        end
    endtask

    task automatic run_return(input string name, input int total, input logic [2:0] empty,
                              input bit give_ack, input bit poke);
        int         rem;
        int         k;
        int         lat;
        int         cnt;
        int         n_coins;
        int         acked;
        int         cur;
        int         fin_rem;
        bit         exp_done;
        logic [2:0] s;
        int         r;

        exp_sel_q.delete();
        exp_rem_q.delete();
        rem = total;
        while (rem != 0) begin
            k = -1;
            for (int j = 0; j < 3; j++) begin
                if (!empty[j] && cv[j] <= rem) k = j;
            end
            if (k < 0) break;
            exp_sel_q.push_back(3'b001 << k);
            rem = rem - cv[k];
            exp_rem_q.push_back(rem);
        end
        n_coins  = exp_sel_q.size();
        exp_done = give_ack ? (rem == 0) : (rem == 0 && n_coins == 0);
        fin_rem  = (give_ack || n_coins == 0) ? rem : total;
        acked    = 0;
        cur      = total;

        i_start_return = 1'b1;
        i_total        = 31'(total);
        i_stock_empty  = empty;
        @(negedge clk);
        i_start_return = 1'b0;
        check({name, " busy_after_start"}, 32'(o_busy), 1);
        check({name, " loaded_remaining"}, 32'(o_remaining), 32'(total));
        check({name, " count_cleared"}, 32'(o_coin_count), 0);
        check({name, " no_early_valid"}, 32'(o_coin_valid), 0);

        for (int step = 0; step < 20; step++) begin
            wait_event(name, lat);
            check({name, " latency"}, 32'(lat), 1);
            if (!o_coin_valid) break;
            check({name, " offer_expected"}, 32'(exp_sel_q.size() != 0), 1);
            if (exp_sel_q.size() == 0) break;
            s = exp_sel_q.pop_front();
            r = exp_rem_q.pop_front();
            check({name, " coin_sel"}, 32'(o_coin_sel), 32'(s));
            if (poke) begin
                poke = 1'b0;
                i_start_return = 1'b1;
                i_total        = 31'd9999;
                @(negedge clk);
                i_start_return = 1'b0;
                check({name, " busy_start_ignored"}, 32'(o_remaining), 32'(cur));
                check({name, " valid_held"}, 32'(o_coin_valid), 1);
                check({name, " sel_held"}, 32'(o_coin_sel), 32'(s));
            end
            if (give_ack) begin
                i_coin_ack = 1'b1;
                @(negedge clk);
                i_coin_ack = 1'b0;
                acked++;
                cur = r;
                check({name, " valid_dropped"}, 32'(o_coin_valid), 0);
                check({name, " remaining_after_ack"}, 32'(o_remaining), 32'(r));
                check({name, " count_after_ack"}, 32'(o_coin_count), 32'(acked));
            end else begin
                cnt = 0;
                while (o_coin_valid && cnt < 40) begin
                    cnt++;
                    @(negedge clk);
                end
                check({name, " valid_hold_cycles"}, 32'(cnt), 15);
                break;
            end
        end

        check({name, " done"}, 32'(o_done), 32'(exp_done));
        check({name, " error"}, 32'(o_error), 32'(!exp_done));
        check({name, " final_remaining"}, 32'(o_remaining), 32'(fin_rem));
        check({name, " final_count"}, 32'(o_coin_count), 32'(acked));
        check({name, " idle_busy"}, 32'(o_busy), 0);
        check({name, " idle_valid"}, 32'(o_coin_valid), 0);
        @(negedge clk);
        check({name, " pulse_one_cycle"}, 32'(o_done | o_error), 0);
        $display("txn %s total=%0d empty=%b ack=%0d -> remaining=%0d coins=%0d", name, total,
                 empty, give_ack, o_remaining, o_coin_count);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " valid"}, 32'(o_coin_valid), 0);
        check({tag, " sel"}, 32'(o_coin_sel), 0);
        check({tag, " busy"}, 32'(o_busy), 0);
        check({tag, " done"}, 32'(o_done), 0);
        check({tag, " error"}, 32'(o_error), 0);
        check({tag, " remaining"}, 32'(o_remaining), 0);
        check({tag, " count"}, 32'(o_coin_count), 0);
    endtask

    initial begin
        int lat;
        reset_n        = 1'b0;
        i_start_return = 1'b0;
        i_total        = '0;
        i_stock_empty  = '0;
        i_coin_ack     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        $display("txn reset -> outputs cleared");
        reset_n = 1'b1;
        @(negedge clk);

        run_return("t1600", 1600, 3'b000, 1'b1, 1'b0);
        run_return("t1000_no_big", 1000, 3'b100, 1'b1, 1'b0);
        run_return("t50_impossible", 50, 3'b000, 1'b1, 1'b0);
        run_return("t500_timeout", 500, 3'b000, 1'b0, 1'b0);
        run_return("t0_zero", 0, 3'b000, 1'b1, 1'b0);
        run_return("t500_busy_start", 500, 3'b000, 1'b1, 1'b1);
        run_return("t2700_no_small", 2700, 3'b001, 1'b1, 1'b0);

        // Reset in the middle of an offer.
        i_start_return = 1'b1;
        i_total        = 31'd1000;
        i_stock_empty  = 3'b000;
        @(negedge clk);
        i_start_return = 1'b0;
        wait_event("mid_reset", lat);
        check("mid_reset offer_up", 32'(o_coin_valid), 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_values("mid_reset");
        $display("txn mid_offer_reset total=1000 -> valid=%0d remaining=%0d", o_coin_valid,
                 o_remaining);
        @(negedge clk);

        run_return("t1600_after_reset", 1600, 3'b000, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
